// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory-access stage: word load/store, branch redirect, registered writeback
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   ex_valid / ex_ready         execute-result handshake; ex_* fields are captured on accept
//   ex_alu_result, ex_rs2_data  address / value / target, and store data
//   ex_opcode, ex_rd, ex_zero   RV32I opcode, destination register, branch-condition flag
//   dmem_*                      request/grant/rvalid data-memory port
//   wb_valid / wb_ready         writeback handshake; wb_* held stable while stalled
//   br_taken, br_target         one-cycle redirect pulse to fetch and its PC
`timescale 1ns/1ps
module mem_access_stage #(
    parameter int N    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [N-1:0]    ex_alu_result,
    input  logic [N-1:0]    ex_rs2_data,
    input  logic [6:0]      ex_opcode,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_zero,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [N-1:0]    dmem_addr,
    output logic [N-1:0]    dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [N-1:0]    dmem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [N-1:0]    wb_data,
    output logic            wb_reg_write,
    output logic            wb_misalign,
    output logic            br_taken,
    output logic [N-1:0]    br_target
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [6:0]   op_q;
    logic [N-1:0] alu_q;
    logic [N-1:0] rs2_q;

    logic   accept;
    logic   ex_is_mem;
    logic   ex_aligned;
    logic   ex_is_alu;
    logic   ex_redirect;
    state_t accept_state;

    assign ex_ready    = (state == S_IDLE) || ((state == S_OUT) && wb_ready);
    assign accept      = ex_valid && ex_ready;
    assign ex_is_mem   = (ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE);
    assign ex_aligned  = (ex_alu_result[1:0] == 2'b00);
    assign ex_is_alu   = (ex_opcode == OP_REG) || (ex_opcode == OP_IMM);
    assign ex_redirect = ((ex_opcode == OP_BRANCH) && ex_zero) ||
                         (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);

    // Request fields come straight from the capture registers, so they stay
    // put for as long as the grant takes.
    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = (state == S_REQ) && (op_q == OP_STORE);
    assign dmem_addr  = alu_q;
    assign dmem_wdata = rs2_q;
    assign wb_valid   = (state == S_OUT);
    assign br_target  = alu_q;

    always_comb begin
        state_nxt    = state;
        // Misaligned accesses skip the memory port and retire directly.
        accept_state = (ex_is_mem && ex_aligned) ? S_REQ : S_OUT;
        case (state)
            S_IDLE:   if (accept) state_nxt = accept_state;
            S_REQ:    if (dmem_gnt) state_nxt = (op_q == OP_STORE) ? S_OUT : S_WAIT_R;
            S_WAIT_R: if (dmem_rvalid) state_nxt = S_OUT;
            S_OUT: begin
                // A same-cycle accept chains straight into the next op with no bubble.
                if (wb_ready) state_nxt = accept ? accept_state : S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            alu_q        <= '0;
            rs2_q        <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            wb_misalign  <= 1'b0;
            br_taken     <= 1'b0;
        end else begin
            state    <= state_nxt;
            // High only in the cycle right after the accepting edge.
            br_taken <= accept && ex_redirect;
            if (accept) begin
                op_q         <= ex_opcode;
                alu_q        <= ex_alu_result;
                rs2_q        <= ex_rs2_data;
                wb_rd        <= ex_rd;
                wb_misalign  <= ex_is_mem && !ex_aligned;
                // Loads gain their write enable only once data returns.
                wb_reg_write <= ex_is_alu && (ex_rd != '0);
                wb_data      <= ex_is_alu ? ex_alu_result : '0;
            end else if ((state == S_WAIT_R) && dmem_rvalid) begin
                wb_data      <= dmem_rdata;
                wb_reg_write <= (wb_rd != '0);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with randomized traffic
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_result, ex_rs2_data;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic        ex_zero;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_ready, wb_reg_write, wb_misalign, br_taken;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, br_target;

    always #5 clk = ~clk;

    mem_access_stage #(.N(32), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_zero(ex_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .wb_misalign(wb_misalign),
        .br_taken(br_taken), .br_target(br_target)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        mis;
        logic        chk_data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    wb_exp_t     exp_wb[$];
    mem_exp_t    exp_mem[$];
    logic [31:0] exp_br[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] ext_mem[logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int gnt_delay = 0;
    int rv_delay  = 0;
    bit rand_mem = 0, rand_wb = 0, spurious = 0;
    bit pend = 0;
    int rv_cnt = 0;
    int wcnt = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] ext_rd(input logic [31:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what one accepted instruction must produce, from the ISA-level rules.
    task automatic push_expect(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic zero);
        wb_exp_t  e;
        mem_exp_t m;
        bit is_mem, al;
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        al = (alu % 4) == 0;
        e.rd = rd; e.data = 0; e.rw = 0; e.chk_data = 1;
        e.mis = is_mem && !al;
        case (op)
            OP_REG, OP_IMM: begin e.data = alu; e.rw = (rd != 0); end
            OP_LOAD: begin
                if (al) begin e.data = model_rd(alu); e.rw = (rd != 0); end
                else e.chk_data = 0;
            end
            OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: e.data = 0;
            default: e.chk_data = 0;
        endcase
        if (is_mem && al) begin
            m.we = (op == OP_STORE); m.addr = alu; m.wdata = rs2;
            exp_mem.push_back(m);
            if (op == OP_STORE) model_mem[alu] = rs2;
        end
        if ((op == OP_BRANCH && zero) || op == OP_JAL || op == OP_JALR) exp_br.push_back(alu);
        exp_wb.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic zero);
        ex_opcode = op; ex_alu_result = alu; ex_rs2_data = rs2; ex_rd = rd; ex_zero = zero;
        ex_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ex_ready) begin
                push_expect(op, alu, rs2, rd, zero);
                @(posedge clk); #1;
                ex_valid = 1'b0;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: ex_ready stayed 0 for op %b", op);
        ex_valid = 1'b0;
    endtask

    // Writeback and redirect monitor.
    always @(negedge clk) begin
        wb_exp_t e;
        logic [31:0] t;
        if (!reset) begin
            if (wb_valid && wb_ready) begin
                if (exp_wb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wb_unexpected: got rd %0d data %h expected no retire", wb_rd, wb_data);
                end else begin
                    e = exp_wb.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_reg_write", wb_reg_write, e.rw);
                    chk("wb_misalign", wb_misalign, e.mis);
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end
            if (br_taken) begin
                if (exp_br.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL br_unexpected: got br_taken 1 target %h expected no pulse", br_target);
                end else begin
                    t = exp_br.pop_front();
                    chk("br_target", br_target, t);
                end
            end
        end
    end

    // Data-memory responder with its own copy of memory.
    initial begin
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        forever begin
            @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0;
            if (pend) begin
                if (rv_cnt > 0) rv_cnt--;
                else begin dmem_rvalid = 1; dmem_rdata = ext_rd(pend_addr); pend = 0; end
            end else if (spurious && ($urandom % 5 == 0)) begin
                dmem_rvalid = 1; dmem_rdata = $urandom;
            end
            if (reset) wcnt = 0;
            else if (dmem_req) begin
                if (exp_mem.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dmem_unexpected: got req addr %h expected no request", dmem_addr);
                end else begin
                    chk("dmem_we", dmem_we, exp_mem[0].we);
                    chk("dmem_addr", dmem_addr, exp_mem[0].addr);
                    if (exp_mem[0].we) chk("dmem_wdata", dmem_wdata, exp_mem[0].wdata);
                    if (wcnt < gnt_delay) wcnt++;
                    else begin
                        dmem_gnt = 1; wcnt = 0;
                        if (exp_mem[0].we) ext_mem[dmem_addr] = dmem_wdata;
                        else begin
                            pend = 1; pend_addr = dmem_addr;
                            rv_cnt = rand_mem ? $urandom_range(0, 3) : rv_delay;
                        end
                        void'(exp_mem.pop_front());
                        if (rand_mem) gnt_delay = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_wb) wb_ready = ($urandom % 4) != 0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ex_ready"}, ex_ready, 1);
        chk({tag, "_flags"}, {dmem_req, dmem_we, wb_valid, wb_reg_write, wb_misalign, br_taken}, 0);
        chk({tag, "_dmem_addr"}, dmem_addr, 0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_br_target"}, br_target, 0);
    endtask

    initial begin
        int cnt;
        logic [6:0] ops [8];
        logic [6:0] op;
        logic [31:0] a;
        ops[0] = OP_REG; ops[1] = OP_IMM; ops[2] = OP_LOAD; ops[3] = OP_STORE;
        ops[4] = OP_BRANCH; ops[5] = OP_JAL; ops[6] = OP_JALR; ops[7] = OP_AUIPC;
        reset = 1; ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_opcode = 0;
        ex_rd = 0; ex_zero = 0; wb_ready = 0;
        ext_mem[32'h104] = 32'h1234_5678; model_mem[32'h104] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 reset = 0;
        wb_ready = 1;

        // ALU result, one-cycle latency
        issue(OP_REG, 32'h7, 0, 5'd5, 0);
        @(negedge clk);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_data", wb_data, 7);
        chk("add_wb_rd", wb_rd, 5);
        chk("add_wb_reg_write", wb_reg_write, 1);
        @(posedge clk); #1;

        // Store with grant held off two cycles
        gnt_delay = 2;
        issue(OP_STORE, 32'h100, 32'hDEAD_BEEF, 5'd3, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dmem_req) break;
            cnt++;
            chk("st_we", dmem_we, 1);
            chk("st_addr", dmem_addr, 32'h100);
            chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
        end
        chk("st_req_cycles", cnt, 3);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_reg_write", wb_reg_write, 0);
        @(posedge clk); #1;

        // Load, immediate grant, data three cycles later
        gnt_delay = 0; rv_delay = 2;
        issue(OP_LOAD, 32'h104, 0, 5'd9, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_valid) break;
            cnt++;
            chk("ld_ex_ready", ex_ready, 0);
        end
        chk("ld_latency", cnt, 4);
        chk("ld_wb_data", wb_data, 32'h1234_5678);
        chk("ld_wb_reg_write", wb_reg_write, 1);
        @(posedge clk); #1;

        // Misaligned load
        issue(OP_LOAD, 32'h102, 0, 5'd4, 0);
        @(negedge clk);
        chk("mis_dmem_req", dmem_req, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_misalign", wb_misalign, 1);
        chk("mis_wb_reg_write", wb_reg_write, 0);
        @(posedge clk); #1;

        // Branches
        issue(OP_BRANCH, 32'h40, 0, 5'd0, 1);
        @(negedge clk);
        chk("bt_br_taken", br_taken, 1);
        chk("bt_br_target", br_target, 32'h40);
        @(negedge clk);
        chk("bt_pulse_end", br_taken, 0);
        @(posedge clk); #1;
        issue(OP_BRANCH, 32'h80, 0, 5'd0, 0);
        @(negedge clk);
        chk("bn_br_taken", br_taken, 0);
        chk("bn_wb_valid", wb_valid, 1);
        @(posedge clk); #1;

        // REG_IMM to x0
        issue(OP_IMM, 32'h55, 0, 5'd0, 0);
        @(negedge clk);
        chk("x0_wb_reg_write", wb_reg_write, 0);
        chk("x0_wb_data", wb_data, 32'h55);
        @(posedge clk); #1;

        // Writeback backpressure then back-to-back accept
        wb_ready = 0;
        issue(OP_REG, 32'h11, 0, 5'd7, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_ex_ready", ex_ready, 0);
            chk("bp_wb_data", wb_data, 32'h11);
            chk("bp_wb_rd", wb_rd, 7);
        end
        @(posedge clk); #1;
        wb_ready = 1;
        issue(OP_IMM, 32'h22, 0, 5'd8, 0);
        @(negedge clk);
        chk("b2b_wb_valid", wb_valid, 1);
        chk("b2b_wb_data", wb_data, 32'h22);
        @(posedge clk); #1;

        // Reset while waiting for load data
        gnt_delay = 0; rv_delay = 8;
        issue(OP_LOAD, 32'h108, 0, 5'd6, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_wb.delete();
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (!pend) break;
            cnt++;
        end
        if (pend) begin
            n_tests++; n_fail++;
            $display("FAIL late_rvalid_timeout: got pending load expected rvalid delivered");
        end
        @(negedge clk);
        chk_reset_outputs("late_rv");
        @(posedge clk); #1;

        // Randomized traffic
        rand_mem = 1; rand_wb = 1; spurious = 1;
        for (int k = 0; k < 300; k++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == OP_LOAD || op == OP_STORE) begin
                a = 32'h100 + ($urandom_range(0, 15) * 4);
                if ($urandom % 6 == 0) a = a + $urandom_range(1, 3);
            end else a = $urandom;
            issue(op, a, $urandom, ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 1'($urandom % 2));
            if ($urandom % 3 == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        rand_wb = 0; spurious = 0;
        wb_ready = 1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (exp_wb.size() == 0 && exp_br.size() == 0 && exp_mem.size() == 0) break;
        end
        @(negedge clk);
        chk("drain_wb", exp_wb.size(), 0);
        chk("drain_br", exp_br.size(), 0);
        chk("drain_mem", exp_mem.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the execute ALU and upstream of writeback.
- Accepts one execute result per ex_valid/ex_ready handshake.
- Performs word loads and stores over a request/grant/rvalid data-memory port, and raises branch/jump redirects.
- Presents a registered result to writeback under a wb_valid/wb_ready handshake.

Parameters:
- N, 32, data and address width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  stage can accept the execute result this cycle.
- ex_alu_result  in  N  ALU result: address, arithmetic value, or branch/jump target.
- ex_rs2_data  in  N  store data.
- ex_opcode  in  7  RV32I opcode.
- ex_rd  in  RD_W  destination register.
- ex_zero  in  1  branch-condition-true flag.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  N  word-aligned byte address.
- dmem_wdata  out  N  store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  N  load data.
- wb_valid  out  1  result valid to writeback.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  RD_W  destination register.
- wb_data  out  N  writeback value.
- wb_reg_write  out  1  register-file write enable.
- wb_misalign  out  1  load/store address not word-aligned.
- br_taken  out  1  one-cycle redirect pulse to fetch.
- br_target  out  N  redirect PC.

Behaviour:
- States: IDLE, REQ, WAIT_R, OUT. Reset (synchronous) forces IDLE.
- Reset values: every output is 0 except ex_ready, which is 1 since it is combinational from IDLE.
- ex_ready = (state==IDLE) || (state==OUT && wb_ready). Accept = ex_valid && ex_ready; all ex_* fields are captured into internal registers on accept.
- Next state on accept, by opcode:
  - LOAD (0000011) or STORE (0100011) with addr[1:0]==0 -> REQ.
  - LOAD/STORE with addr[1:0]!=0 -> OUT with wb_misalign=1, wb_reg_write=0, and no memory request.
  - All other opcodes -> OUT.
- REQ:
  - Drives dmem_req=1, dmem_addr=captured result, dmem_we=(STORE), dmem_wdata=captured rs2.
  - Request fields stay stable until dmem_gnt.
  - On gnt: store -> OUT; load -> WAIT_R.
  - dmem_req drops in the cycle after gnt.
- WAIT_R: on dmem_rvalid, capture dmem_rdata into wb_data and go to OUT. There is no timeout.
- OUT:
  - wb_valid=1; wb_* held stable until wb_ready.
  - On wb_ready without a new accept -> IDLE. With a new accept in the same cycle -> next state per accept rules (back-to-back, no bubble).
- wb_data rules:
  - REG_REG (0110011) and REG_IMM (0010011): wb_data = alu_result.
  - LOAD: wb_data = rdata.
  - STORE, BRANCH, JAL, JALR: wb_data = 0.
- wb_reg_write = 1 only for REG_REG, REG_IMM, or a successful LOAD, and only when rd != 0.
- Jumps (JAL 1101111, JALR 1100111) redirect only; link writes are not performed in this revision (wb_reg_write=0).
- br_taken:
  - Pulses for exactly the one cycle after accept, for BRANCH (1100011) with ex_zero=1, or for JAL/JALR.
  - br_target = captured alu_result.
  - Not-taken branches still retire through OUT with no pulse.
- Unknown opcode: retires through OUT with wb_reg_write=0 and no memory access.
- Latency from accept edge to wb_valid:
  - ALU/branch: 1 cycle.
  - Store: 1 + grant wait + 1.
  - Load: 1 + grant wait + rvalid wait + 1.
- Reset mid-operation: returns to IDLE and drops dmem_req, wb_valid and br_taken on that edge. A dmem_rvalid arriving after reset is ignored.
- Loads and stores are word-only; funct3 width variants are not supported.
- dmem_rvalid outside WAIT_R is ignored.

Test Plan:
- ADD result: ex_valid with opcode 0110011, alu_result 0x0000_0007, rd 5 -> next cycle wb_valid=1, wb_data=7, wb_rd=5, wb_reg_write=1.
- Store: opcode 0100011, addr 0x100, rs2 0xDEAD_BEEF, gnt held low 2 cycles -> dmem_req/we high and addr/wdata stable for 3 cycles; wb_valid one cycle after gnt with wb_reg_write=0.
- Load: addr 0x104, gnt immediately, rvalid 3 cycles later with 0x1234_5678 -> wb_data=0x1234_5678, wb_reg_write=1; ex_ready=0 throughout.
- Misaligned load: addr 0x102 -> no dmem_req; wb_valid next cycle with wb_misalign=1, wb_reg_write=0.
- Branch and writeback rules:
  - BRANCH with zero=1, alu_result 0x0000_0040 -> br_taken one cycle, br_target=0x40.
  - Same with zero=0 -> no pulse.
  - REG_IMM with rd=0 -> wb_reg_write=0.
- Backpressure and reset:
  - wb_ready held low 4 cycles in OUT -> outputs stable, ex_ready=0.
  - Raising wb_ready with ex_valid high gives back-to-back accept.
  - Asserting reset in WAIT_R -> IDLE next edge, a late rvalid is ignored, and all outputs return to reset values.
